conv1_bram_port_arbiter: RTL and testbench

Arbitrates port A of the Conv_2D_1 input/output BRAM between two requesters: the RISC-V host (loads input feature maps, reads results) and the Conv_2D_1 engine (reads activations, writes outputs). Round-robin, one access per cycle, fixed-latency read responses routed back to the originator, out-of-range detection, and optional host lock-out while the engine runs. Sits between the SoC interconnect / conv engine and BRAM_PORTA_0 of the BRAM wrapper; port B is untouched.

---
 rtl/conv1_bram_port_arbiter_if.sv | 31 +++
 rtl/conv1_bram_port_arbiter.sv | 146 ++++++++++++++
 tb/tb_conv1_bram_port_arbiter.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv1_bram_port_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : conv1_bram_port_arbiter_if
//  Purpose  : One requester's view of the Conv_2D_1 BRAM port-A arbiter.
//             The arbiter has one instance for the RISC-V host and one for
//             the Conv_2D_1 engine.
//  Signals  : valid/ready    request handshake (ready = grant this cycle)
//             addr           byte address, bits [1:0] ignored
//             we             byte write enables, zero means read
//             wdata          write data
//             rvalid/rdata   one-cycle read response
//             err            one-cycle error pulse (out of range / blocked)
//  Modports : master = requester side, slave = arbiter side
//  Revision : 1.0  initial release
// ============================================================================
interface conv1_bram_port_arbiter_if;
  logic        valid;
  logic        ready;
  logic [31:0] addr;
  logic [3:0]  we;
  logic [31:0] wdata;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  modport master (output valid, addr, we, wdata,
                  input  ready, rvalid, rdata, err);
  modport slave  (input  valid, addr, we, wdata,
                  output ready, rvalid, rdata, err);
endinterface
`default_nettype wire

// File: rtl/conv1_bram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : conv1_bram_port_arbiter
//  Purpose  : Round-robin arbiter for port A of the Conv_2D_1 BRAM, shared by
//             the RISC-V host and the Conv_2D_1 engine. One access per cycle,
//             fixed two-edge read latency, responses routed to the originator,
//             out-of-range squash, optional host lock-out.
//  Ports    : clk, rst      clock, synchronous active-high reset
//             host, eng     requester interfaces (slave modport)
//             eng_lock      engine run-active (used only with the guard)
//             bram_en/we/addr/din  BRAM_PORTA_0 request outputs
//             bram_dout     BRAM_PORTA_0 read data
//  Options  : CONV1_ARB_HOST_GUARD_EN - when defined, host requests accepted
//             while eng_lock=1 are squashed and reported via host.err.
//  Revision : 1.0  initial release
// ============================================================================
module conv1_bram_port_arbiter #(
  parameter int DEPTH_WORDS = 1024
) (
  input  wire logic                 clk,
  input  wire logic                 rst,
  conv1_bram_port_arbiter_if.slave  host,
  conv1_bram_port_arbiter_if.slave  eng,
  input  wire logic                 eng_lock,
  output logic                      bram_en,
  output logic [3:0]                bram_we,
  output logic [31:0]               bram_addr,
  output logic [31:0]               bram_din,
  input  wire logic [31:0]          bram_dout
);

  localparam logic [29:0] DEPTH_IDX = 30'(DEPTH_WORDS);

  // Priority pointer: 0 favours the engine, 1 favours the host.
  logic        ptr_host;
  logic        gnt_host, gnt_eng, accept;
  logic        out_of_range, host_blocked, squash;
  logic [31:0] sel_addr, sel_wdata;
  logic [3:0]  sel_we;

  // Response pipeline metadata: stage 1 = issue cycle, stage 2 = BRAM cycle.
  logic s1_vld, s1_rd, s1_host, s1_sq;
  logic s2_vld, s2_rd, s2_host, s2_sq;

  always_comb begin
    gnt_eng  = 1'b0;
    gnt_host = 1'b0;
    if (!rst) begin
      if (eng.valid && (!host.valid || !ptr_host)) gnt_eng = 1'b1;
      else if (host.valid)                         gnt_host = 1'b1;
    end
  end

  assign host.ready = gnt_host;
  assign eng.ready  = gnt_eng;
  assign accept     = gnt_host | gnt_eng;

  assign sel_addr  = gnt_host ? host.addr  : eng.addr;
  assign sel_we    = gnt_host ? host.we    : eng.we;
  assign sel_wdata = gnt_host ? host.wdata : eng.wdata;

  // Byte-offset bits never reach the BRAM.
  logic [1:0] unused_sel_lsbs;
  assign unused_sel_lsbs = sel_addr[1:0];

  assign out_of_range = (sel_addr[31:2] >= DEPTH_IDX);

`ifdef CONV1_ARB_HOST_GUARD_EN
  assign host_blocked = gnt_host & eng_lock;
`else
  logic unused_eng_lock;
  assign unused_eng_lock = eng_lock;
  assign host_blocked    = 1'b0;
`endif

  assign squash = out_of_range | host_blocked;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_host <= 1'b0;
    end else if (gnt_eng) begin
      ptr_host <= 1'b1;
    end else if (gnt_host) begin
      ptr_host <= 1'b0;
    end
  end

  // Issue stage: BRAM is driven only for accepted, non-squashed requests.
  always_ff @(posedge clk) begin
    if (rst) begin
      bram_en   <= 1'b0;
      bram_we   <= 4'h0;
      bram_addr <= 32'h0;
      bram_din  <= 32'h0;
      s1_vld    <= 1'b0;
      s1_rd     <= 1'b0;
      s1_host   <= 1'b0;
      s1_sq     <= 1'b0;
    end else begin
      bram_en   <= accept & ~squash;
      bram_we   <= (accept & ~squash) ? sel_we : 4'h0;
      bram_addr <= (accept & ~squash) ? {sel_addr[31:2], 2'b00} : 32'h0;
      bram_din  <= (accept & ~squash) ? sel_wdata : 32'h0;
      s1_vld    <= accept;
      s1_rd     <= (sel_we == 4'h0);
      s1_host   <= gnt_host;
      s1_sq     <= squash;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_vld  <= 1'b0;
      s2_rd   <= 1'b0;
      s2_host <= 1'b0;
      s2_sq   <= 1'b0;
    end else begin
      s2_vld  <= s1_vld;
      s2_rd   <= s1_rd;
      s2_host <= s1_host;
      s2_sq   <= s1_sq;
    end
  end

  // Response stage: bram_dout is valid here for the request issued one
  // cycle earlier. Squashed reads still answer, with zero data.
  always_ff @(posedge clk) begin
    if (rst) begin
      host.rvalid <= 1'b0;
      host.rdata  <= 32'h0;
      host.err    <= 1'b0;
      eng.rvalid  <= 1'b0;
      eng.rdata   <= 32'h0;
      eng.err     <= 1'b0;
    end else begin
      host.rvalid <= s2_vld & s2_rd & s2_host;
      host.rdata  <= (s2_vld & s2_rd & s2_host & ~s2_sq) ? bram_dout : 32'h0;
      host.err    <= s2_vld & s2_sq & s2_host;
      eng.rvalid  <= s2_vld & s2_rd & ~s2_host;
      eng.rdata   <= (s2_vld & s2_rd & ~s2_host & ~s2_sq) ? bram_dout : 32'h0;
      eng.err     <= s2_vld & s2_sq & ~s2_host;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_conv1_bram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_conv1_bram_port_arbiter
//  Purpose  : Self-checking bench for conv1_bram_port_arbiter. A behavioural
//             BRAM (write-first) sits on port A; a reference model of the
//             arbitration rules, a shadow memory and a queue of due responses
//             predict every grant, BRAM access and response.
//  Revision : 1.0  initial release
// ============================================================================
module tb_conv1_bram_port_arbiter;

`ifdef CONV1_ARB_HOST_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif
  localparam int DEPTH = 1024;

  typedef struct {
    logic        valid;
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    int unsigned due;
    bit          host;
    bit          rv;
    logic [31:0] data;
    bit          err;
  } resp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        eng_lock = 1'b0;
  logic        bram_en;
  logic [3:0]  bram_we;
  logic [31:0] bram_addr, bram_din;
  logic [31:0] bram_dout = 32'h0;

  conv1_bram_port_arbiter_if host_if ();
  conv1_bram_port_arbiter_if eng_if ();

  conv1_bram_port_arbiter #(.DEPTH_WORDS(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .host      (host_if),
    .eng       (eng_if),
    .eng_lock  (eng_lock),
    .bram_en   (bram_en),
    .bram_we   (bram_we),
    .bram_addr (bram_addr),
    .bram_din  (bram_din),
    .bram_dout (bram_dout)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] we);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (we[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // Behavioural BRAM port A, write-first.
  logic [31:0] bram_mem [DEPTH];
  logic [31:0] bram_nv;
  always @(posedge clk) begin
    if (bram_en) begin
      bram_nv = merge(bram_mem[bram_addr[11:2]], bram_din, bram_we);
      bram_mem[bram_addr[11:2]] = bram_nv;
      bram_dout <= bram_nv;
    end
  end

  // Reference model state.
  logic [31:0] ref_mem [DEPTH];
  resp_t       exp_q[$];
  bit          ptr_host;
  int unsigned cyc;
  logic        m_hg, m_eg, obs_hg, obs_eg;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic req_t mk(input logic v, input logic [31:0] a, input logic [3:0] we,
                              input logic [31:0] d);
    req_t r;
    r.valid = v; r.addr = a; r.we = we; r.wdata = d;
    return r;
  endfunction

  function automatic req_t rnd_req();
    req_t        r;
    int unsigned idx;
    idx = ($urandom_range(15) == 0) ? DEPTH + $urandom_range(7) : $urandom_range(15);
    r.valid = 1'b1;
    r.addr  = (idx << 2) | $urandom_range(3);
    r.we    = ($urandom_range(1) == 1) ? 4'h0 : 4'($urandom_range(15));
    r.wdata = $urandom;
    return r;
  endfunction

  // One clock cycle: drive at the falling edge, check grants, predict the
  // rising edge, then check BRAM outputs and responses 1 time unit later.
  task automatic step(input req_t h, input req_t e, input logic lk, input logic r);
    resp_t       rs;
    logic        is_h, sq;
    logic [31:0] a, wd, rd_val;
    logic [3:0]  we;
    int unsigned idx;
    logic        x_en;
    logic [3:0]  x_we;
    logic [31:0] x_addr, x_din;
    logic        hrv, herr, erv, eerr;
    logic [31:0] hrd, erd;

    @(negedge clk);
    rst           = r;
    eng_lock      = lk;
    host_if.valid = h.valid; host_if.addr = h.addr; host_if.we = h.we; host_if.wdata = h.wdata;
    eng_if.valid  = e.valid; eng_if.addr  = e.addr; eng_if.we  = e.we; eng_if.wdata  = e.wdata;
    #1;
    m_eg = !r && e.valid && (!h.valid || !ptr_host);
    m_hg = !r && h.valid && !m_eg;
    obs_hg = host_if.ready;
    obs_eg = eng_if.ready;
    chk("host_ready", 32'(obs_hg), 32'(m_hg));
    chk("eng_ready", 32'(obs_eg), 32'(m_eg));

    @(posedge clk);
    cyc++;
    x_en = 1'b0; x_we = 4'h0; x_addr = 32'h0; x_din = 32'h0;
    if (r) begin
      exp_q.delete();
      ptr_host = 1'b0;
    end else if (m_hg || m_eg) begin
      is_h = m_hg;
      a    = is_h ? h.addr  : e.addr;
      we   = is_h ? h.we    : e.we;
      wd   = is_h ? h.wdata : e.wdata;
      idx  = a[31:2];
      sq   = (idx >= DEPTH) || (GUARD && is_h && lk);
      rd_val = 32'h0;
      if (!sq) begin
        if (we != 4'h0) ref_mem[idx] = merge(ref_mem[idx], wd, we);
        else            rd_val = ref_mem[idx];
        x_en = 1'b1; x_we = we; x_addr = {a[31:2], 2'b00}; x_din = wd;
      end
      if (we == 4'h0 || sq) begin
        rs.due = cyc + 2; rs.host = is_h; rs.rv = (we == 4'h0); rs.data = rd_val; rs.err = sq;
        exp_q.push_back(rs);
      end
      ptr_host = !is_h;
    end
    #1;
    hrv = 1'b0; herr = 1'b0; hrd = 32'h0;
    erv = 1'b0; eerr = 1'b0; erd = 32'h0;
    if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
      rs = exp_q.pop_front();
      if (rs.host) begin hrv = rs.rv; hrd = rs.data; herr = rs.err; end
      else         begin erv = rs.rv; erd = rs.data; eerr = rs.err; end
    end
    chk("host_rvalid", 32'(host_if.rvalid), 32'(hrv));
    chk("host_rdata",  host_if.rdata, hrd);
    chk("host_err",    32'(host_if.err), 32'(herr));
    chk("eng_rvalid",  32'(eng_if.rvalid), 32'(erv));
    chk("eng_rdata",   eng_if.rdata, erd);
    chk("eng_err",     32'(eng_if.err), 32'(eerr));
    chk("bram_en",     32'(bram_en), 32'(x_en));
    chk("bram_we",     32'(bram_we), 32'(x_we));
    if (x_en || r) begin
      chk("bram_addr", bram_addr, x_addr);
      chk("bram_din",  bram_din, x_din);
    end
  endtask

  req_t idle, hp, ep;

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      bram_mem[i] = 32'h0;
      ref_mem[i]  = 32'h0;
    end
    cyc = 0;
    ptr_host = 1'b0;
    idle = mk(1'b0, 32'h0, 4'h0, 32'h0);

    // Reset, with a request pending to confirm ready stays low.
    step(mk(1'b1, 32'h4, 4'h0, 32'h0), idle, 1'b0, 1'b1);
    step(idle, idle, 1'b0, 1'b1);
    step(idle, idle, 1'b0, 1'b0);

    // Host write then read of 0x10.
    step(mk(1'b1, 32'h10, 4'hF, 32'hDEADBEEF), idle, 1'b0, 1'b0);
    step(mk(1'b1, 32'h10, 4'h0, 32'h0), idle, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(idle, idle, 1'b0, 1'b0);

    // Fresh reset, then both requesters valid for six cycles: alternate grants.
    step(idle, idle, 1'b0, 1'b1);
    hp = mk(1'b1, 32'h10, 4'h0, 32'h0);
    ep = mk(1'b1, 32'h20, 4'h0, 32'h0);
    for (int i = 0; i < 6; i++) begin
      step(hp, ep, 1'b0, 1'b0);
      chk("alt_eng_grant", 32'(obs_eg), 32'((i % 2) == 0));
      if (m_hg) hp.addr = hp.addr + 32'h4;
      if (m_eg) ep.addr = ep.addr + 32'h4;
    end
    for (int i = 0; i < 3; i++) step(idle, idle, 1'b0, 1'b0);

    // Out-of-range host read at word 1024.
    step(mk(1'b1, 32'h1000, 4'h0, 32'h0), idle, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(idle, idle, 1'b0, 1'b0);

    // Host write under engine lock, then engine reads addr 0.
    step(idle, mk(1'b1, 32'h0, 4'hF, 32'h12345678), 1'b0, 1'b0);
    step(mk(1'b1, 32'h0, 4'hF, 32'h55), idle, 1'b1, 1'b0);
    step(idle, mk(1'b1, 32'h0, 4'h0, 32'h0), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(idle, idle, 1'b0, 1'b0);

    // Engine byte write over a full word, then read back.
    step(idle, mk(1'b1, 32'h40, 4'hF, 32'h11223344), 1'b0, 1'b0);
    step(idle, mk(1'b1, 32'h40, 4'b0010, 32'h0000AB00), 1'b0, 1'b0);
    step(idle, mk(1'b1, 32'h40, 4'h0, 32'h0), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(idle, idle, 1'b0, 1'b0);

    // Two reads accepted, then reset for one cycle: nothing comes back.
    step(mk(1'b1, 32'h40, 4'h0, 32'h0), mk(1'b1, 32'h10, 4'h0, 32'h0), 1'b0, 1'b0);
    step(mk(1'b1, 32'h40, 4'h0, 32'h0), idle, 1'b0, 1'b0);
    step(idle, idle, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(idle, idle, 1'b0, 1'b0);
    step(mk(1'b1, 32'h8, 4'h0, 32'h0), mk(1'b1, 32'hC, 4'h0, 32'h0), 1'b0, 1'b0);
    chk("post_rst_eng_first", 32'(obs_eg), 32'h1);
    step(mk(1'b1, 32'h8, 4'h0, 32'h0), idle, 1'b0, 1'b0);

    // Randomized traffic; a pending request is held until granted.
    hp = idle;
    ep = idle;
    for (int n = 0; n < 400; n++) begin
      if (!hp.valid && $urandom_range(3) != 0) hp = rnd_req();
      if (!ep.valid && $urandom_range(3) != 0) ep = rnd_req();
      step(hp, ep, 1'($urandom_range(1)), 1'b0);
      if (m_hg) hp.valid = 1'b0;
      if (m_eg) ep.valid = 1'b0;
    end
    for (int i = 0; i < 4; i++) step(idle, idle, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
